// File: rtl/vga_scan_controller_if.sv
// Pixel-query bus: the scan controller issues coordinates, the overlay answers with a fill bit.
interface vga_scan_controller_if;
  logic [11:0] x_p;
  logic [11:0] y_p;
  logic        is_filled;

  modport master (output x_p, output y_p, input  is_filled);
  modport slave  (input  x_p, input  y_p, output is_filled);
endinterface

// File: rtl/vga_scan_controller.sv
// VGA raster timing generator with registered RGB/sync outputs driven from overlay fill bits.
// Define VGA_BORDER_EN to force FG_COLOR on the outermost visible rows and columns.
module vga_scan_controller #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FP      = 56,
  parameter int unsigned H_SYNC    = 120,
  parameter int unsigned H_BP      = 64,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FP      = 37,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 23,
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic                         clk,
  input  logic                         reset,
  vga_scan_controller_if.master        pix,
  output logic                         hsync,
  output logic                         vsync,
  output logic [11:0]                  rgb,
  output logic                         visible,
  output logic                         frame_start
);

  localparam int unsigned CNT_W    = 12;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0] div_cnt;
  logic             pe;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_n, v_n;
  logic             vis_n, hs_n, vs_n, fs_n, border_n;
  logic [11:0]      rgb_n;

  assign pe = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Coordinates hold at the last visible pixel/line through blanking.
  assign pix.x_p = (h_cnt > CNT_W'(H_VISIBLE - 1)) ? CNT_W'(H_VISIBLE - 1) : h_cnt;
  assign pix.y_p = (v_cnt > CNT_W'(V_VISIBLE - 1)) ? CNT_W'(V_VISIBLE - 1) : v_cnt;

  // Raster position after the next pixel enable.
  always_comb begin
    h_n = h_cnt + CNT_W'(1);
    v_n = v_cnt;
    if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
      h_n = '0;
      v_n = (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  // Output values for the pixel that (h_n, v_n) addresses; is_filled already answers for it.
  always_comb begin
    vis_n    = (h_n < CNT_W'(H_VISIBLE)) && (v_n < CNT_W'(V_VISIBLE));
    hs_n     = (h_n >= CNT_W'(HS_START)) && (h_n < CNT_W'(HS_END));
    vs_n     = (v_n >= CNT_W'(VS_START)) && (v_n < CNT_W'(VS_END));
    fs_n     = (h_n == '0) && (v_n == '0);
    border_n = 1'b0;
`ifdef VGA_BORDER_EN
    border_n = (h_n == '0) || (h_n == CNT_W'(H_VISIBLE - 1)) ||
               (v_n == '0) || (v_n == CNT_W'(V_VISIBLE - 1));
`endif
    rgb_n = 12'h000;
    if (vis_n) begin
      rgb_n = (pix.is_filled || border_n) ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      rgb         <= 12'h000;
      visible     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pe) begin
        div_cnt     <= '0;
        h_cnt       <= h_n;
        v_cnt       <= v_n;
        hsync       <= hs_n;
        vsync       <= vs_n;
        rgb         <= rgb_n;
        visible     <= vis_n;
        frame_start <= fs_n;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Self-checking bench for vga_scan_controller using a shrunken raster so whole frames run quickly.
module tb_vga_scan_controller;

  localparam int unsigned HV = 16, HFP = 2, HS = 3, HBP = 2;
  localparam int unsigned VV = 8,  VFP = 1, VS = 2, VBP = 1;
  localparam int unsigned CD = 3;
  localparam int unsigned HT = HV + HFP + HS + HBP;
  localparam int unsigned VT = VV + VFP + VS + VBP;
  localparam int unsigned FRAME_CLKS = HT * VT * CD;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
`ifdef VGA_BORDER_EN
  localparam int unsigned BORDER_PIX = 2 * HV + 2 * (VV - 2);
`else
  localparam int unsigned BORDER_PIX = 0;
`endif

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        vis;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync, vsync, visible, frame_start;
  logic [11:0] rgb;

  int          checks = 0;
  int          failures = 0;
  int unsigned since_rst = 0;
  int          mode = 0;
  int unsigned ov_sx, ov_sy;
  pix_t        sb[$];

  vga_scan_controller_if bus ();

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(CD), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix(bus.master),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .visible(visible),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) since_rst <= 0;
    else       since_rst <= since_rst + 1;
  end

  function automatic logic fill_of(int m, int unsigned x, int unsigned y);
    case (m)
      1:       return 1'b1;
      2:       return (x == 5) || (x == 10 && y == 3);
      default: return 1'b0;
    endcase
  endfunction

  // Overlay: answers for the successor of the current coordinates.
  always @(negedge clk) begin
    if (bus.x_p == 12'(HV - 1)) begin
      ov_sx = 0;
      ov_sy = (bus.y_p == 12'(VV - 1)) ? 0 : 32'(bus.y_p) + 1;
    end else begin
      ov_sx = 32'(bus.x_p) + 1;
      ov_sy = 32'(bus.y_p);
    end
    bus.is_filled = fill_of(mode, ov_sx, ov_sy);
  end

  // Expected outputs after the k-th pixel enable since reset.
  function automatic pix_t model(int unsigned k, int m);
    int unsigned kk, h, v;
    logic        bord;
    pix_t        p;
    kk    = k % (HT * VT);
    h     = kk % HT;
    v     = kk / HT;
    p.x   = 12'((h < HV) ? h : HV - 1);
    p.y   = 12'((v < VV) ? v : VV - 1);
    p.vis = (h < HV) && (v < VV);
    p.hs  = (h >= HV + HFP) && (h < HV + HFP + HS);
    p.vs  = (v >= VV + VFP) && (v < VV + VFP + VS);
    p.fs  = (h == 0) && (v == 0);
    bord  = 1'b0;
`ifdef VGA_BORDER_EN
    bord  = (h == 0) || (h == HV - 1) || (v == 0) || (v == VV - 1);
`endif
    p.rgb = !p.vis ? 12'h000 : ((fill_of(m, h, v) || bord) ? FG : BG);
    return p;
  endfunction

  task automatic test_reset;
    pix_t got;
    mode  = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.x_p, bus.y_p, visible, hsync, vsync, frame_start, rgb};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    @(negedge clk) reset = 1'b0;
    for (int e = 1; e <= int'(CD); e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.x_p !== 12'((e == int'(CD)) ? 1 : 0) || visible !== 1'(e == int'(CD))) begin
        failures++;
        $display("FAIL first_pe clk=%0d x_p=%0d visible=%b", e, bus.x_p, visible);
      end
    end
  endtask

  task automatic test_blank_frame;
    int hs_c = 0, vs_c = 0, fs_c = 0, rgb_nz = 0;
    mode = 0;
    repeat (2 * CD) @(posedge clk);
    repeat (FRAME_CLKS) begin
      @(posedge clk);
      #1;
      if (hsync === 1'b1) hs_c++;
      if (vsync === 1'b1) vs_c++;
      if (frame_start === 1'b1) fs_c++;
      if (rgb !== 12'h000) rgb_nz++;
    end
    checks++;
    if (hs_c != int'(VT * HS * CD)) begin
      failures++; $display("FAIL hsync_clks got=%0d exp=%0d", hs_c, VT * HS * CD);
    end
    checks++;
    if (vs_c != int'(VS * HT * CD)) begin
      failures++; $display("FAIL vsync_clks got=%0d exp=%0d", vs_c, VS * HT * CD);
    end
    checks++;
    if (fs_c != 1) begin
      failures++; $display("FAIL frame_start_count got=%0d exp=1", fs_c);
    end
    checks++;
    if (rgb_nz != 0) begin
      failures++; $display("FAIL blank_rgb nonzero_clks=%0d exp=0", rgb_nz);
    end
  endtask

  task automatic test_filled;
    int vis_c = 0;
    mode = 1;
    repeat (2 * CD) @(posedge clk);
    repeat (FRAME_CLKS) begin
      @(posedge clk);
      #1;
      if (visible === 1'b1) vis_c++;
      checks++;
      if (rgb !== (visible ? FG : 12'h000)) begin
        failures++; $display("FAIL filled_rgb got=%h visible=%b", rgb, visible);
      end
    end
    checks++;
    if (vis_c != int'(HV * VV * CD)) begin
      failures++; $display("FAIL visible_clks got=%0d exp=%0d", vis_c, HV * VV * CD);
    end
    mode = 0;
  endtask

  task automatic test_lookahead;
    pix_t exp_p, got;
    mode = 2;
    repeat (2 * CD) @(posedge clk);
    sb.delete();
    repeat (FRAME_CLKS + HT * CD) begin
      @(negedge clk);
      if ((since_rst + 1) % CD == 0) sb.push_back(model((since_rst + 1) / CD, mode));
      @(posedge clk);
      #1;
      got = {bus.x_p, bus.y_p, visible, hsync, vsync, frame_start, rgb};
      checks++;
      if (sb.size() != 0) begin
        exp_p = sb.pop_front();
        if (got !== exp_p) begin
          failures++; $display("FAIL pixel got=%h exp=%h", got, exp_p);
        end
      end else if (frame_start !== 1'b0) begin
        failures++; $display("FAIL frame_start_width got=%b exp=0", frame_start);
      end
    end
    mode = 0;
  endtask

  task automatic test_mid_reset;
    int unsigned target;
    int          budget;
    pix_t        got;
    mode   = 0;
    target = CD * (5 * HT + 10) + CD - 1;
    budget = 2 * FRAME_CLKS;
    do begin
      @(negedge clk);
      budget--;
    end while ((since_rst % FRAME_CLKS) != target && budget > 0);
    checks++;
    if (budget <= 0 || bus.x_p !== 12'd10 || bus.y_p !== 12'd5) begin
      failures++; $display("FAIL mid_position x_p=%0d y_p=%0d exp=10,5", bus.x_p, bus.y_p);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    got = {bus.x_p, bus.y_p, visible, hsync, vsync, frame_start, rgb};
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL mid_reset_state got=%h exp=0", got);
    end
    @(negedge clk) reset = 1'b0;
    budget = FRAME_CLKS + 10;
    while (frame_start !== 1'b1 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checks++;
    if (frame_start !== 1'b1 || since_rst != FRAME_CLKS) begin
      failures++; $display("FAIL frame_after_reset at_clk=%0d exp=%0d", since_rst, FRAME_CLKS);
    end
  endtask

  task automatic test_border;
    int fg_c = 0, odd_c = 0;
    mode = 0;
    repeat (2 * CD) @(posedge clk);
    repeat (FRAME_CLKS) begin
      @(posedge clk);
      #1;
      if (rgb === FG) fg_c++;
      else if (rgb !== 12'h000) odd_c++;
    end
    checks++;
    if (fg_c != int'(BORDER_PIX * CD) || odd_c != 0) begin
      failures++; $display("FAIL border_pixels got=%0d exp=%0d other=%0d", fg_c, BORDER_PIX * CD, odd_c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_blank_frame();
    test_filled();
    test_lookahead();
    test_mid_reset();
    test_border();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

- Generates 800x600@72 Hz VGA timing from the 100 MHz board clock.
- Drives the pixel coordinates `x_p`/`y_p` that the overlay blocks (score board, playfield renderers) consume.
- Samples their `is_filled` answer and turns it into registered RGB and sync outputs.
- Sits at the display end of the pixel-query interface: it issues coordinates and consumes fill bits.

## Interface
Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (≥2)
- FG_COLOR, 12'hFFF, RGB444 colour for filled pixels
- BG_COLOR, 12'h000, RGB444 colour for unfilled visible pixels

Ports:
- clk, in, 1, system clock, 100 MHz
- reset, in, 1, synchronous, active-high
- is_filled, in, 1, fill bit from the overlay for the pixel after (x_p, y_p); valid one clk after x_p/y_p change
- x_p, out, 12, current horizontal pixel, clamped to 0..H_VISIBLE-1
- y_p, out, 12, current line, clamped to 0..V_VISIBLE-1
- hsync, out, 1, horizontal sync, active-high
- vsync, out, 1, vertical sync, active-high
- rgb, out, 12, {R[3:0],G[3:0],B[3:0]}
- visible, out, 1, high while rgb carries a visible pixel
- frame_start, out, 1, one-clk pulse when pixel (0,0) starts on rgb

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1. Pixel enable `pe` = (div_cnt == CLK_DIV-1).
- Counters advance only on `pe`:
  - `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters = 1040.
  - `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = sum of the V_* parameters = 666.
  - `v_cnt` increments when `h_cnt` wraps. Both wrap to 0 together at (1039, 665).
- Coordinate outputs, combinational from the counters:
  - x_p = min(h_cnt, H_VISIBLE-1).
  - y_p = min(v_cnt, V_VISIBLE-1).
- Lookahead contract: the overlay answers for the successor pixel of (x_p, y_p).
  - Successor of (x_p, y_p) is (x_p+1, y_p).
  - At x_p = 799 the successor is (0, y_p+1).
  - At (799, 599) the successor is (0, 0).
- Output registers, updated on `pe` from the next counter values (h_n, v_n):
  - vis_n = h_n < H_VISIBLE && v_n < V_VISIBLE.
  - visible <= vis_n.
  - rgb <= vis_n ? (is_filled ? FG_COLOR : BG_COLOR) : 12'h000.
  - hsync <= h_n in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. [856, 976).
  - vsync <= v_n in [637, 643).
  - frame_start <= (h_n == 0 && v_n == 0). frame_start is cleared on the following clk, so it is one clk wide.
- During blanking, `is_filled` is ignored and rgb is forced to 0.

## Timing
- Reset values:
  - div_cnt = 0, h_cnt = 0, v_cnt = 0, so x_p = y_p = 0.
  - hsync = 0, vsync = 0, rgb = 0, visible = 0, frame_start = 0.
- Reset takes priority over `pe` in the same cycle.
- Reset mid-frame restarts the scan at (0,0) on the next clk with all outputs in their reset state. No partial-line recovery.
- First `pe` after reset occurs CLK_DIV clks after reset deasserts. That `pe` loads the colour for pixel (1,0) and advances h_cnt to 1. Pixel (0,0) is therefore not displayed in the first frame after reset.
- Latency: `is_filled` is sampled on the `pe` clk, which is CLK_DIV-1 clks after x_p changes. rgb for a pixel appears on the clk after that sampling.
- Counters and outputs change together, every CLK_DIV clks; there are no glitches between `pe` events.
- Frame period = 1040 × 666 × CLK_DIV clks = 1,385,280 clks at CLK_DIV = 2.

## Configuration
- Macro `VGA_BORDER_EN`.
- When defined: a visible pixel with x = 0, x = H_VISIBLE-1, y = 0 or y = V_VISIBLE-1 drives FG_COLOR regardless of `is_filled`.
- When undefined: no border override; rgb follows `is_filled` only.
- Sync timing and coordinate behaviour are identical in both builds.

## Test plan
- Reset, then hold is_filled = 0 for one frame -> hsync high exactly 120 pixels per line (240 clks), vsync high 6 lines. frame_start pulses once per 1,385,280 clks. rgb = 0 throughout.
- Tie is_filled = 1 -> rgb = 12'hFFF exactly when visible = 1, and 12'h000 when visible = 0. Count 480,000 visible pixels per frame.
- Model is_filled = (successor x == 5) -> rgb = FG only on column 5 of each visible line, confirming lookahead alignment.
- Sweep the scan -> x_p holds 799 through horizontal blanking and y_p holds 599 through vertical blanking. The (799,599) -> (0,0) wrap occurs with frame_start on the first pixel.
- Assert reset for 1 clk at h_cnt = 500, v_cnt = 300 -> next clk x_p = y_p = 0 and all outputs 0. The next frame_start arrives one full frame later.
- With `VGA_BORDER_EN` defined and is_filled = 0 -> rgb = FG on line 0, line 599, column 0 and column 799, and 0 elsewhere. Without the macro -> rgb = 0 everywhere.
